// File: rtl/sys_defs.sv
// Shared execute-stage definitions: operand/tag widths, the M-extension
// funct3 codes, the default multiplier depth and the per-stage packet that
// flows down the multiplier pipeline.
//
// The issue width is a property of the execute stage, which instantiates
// one ex_mult_unit per issue lane.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef MD_MUL_FUN3
`define MD_MUL_FUN3    3'b000
`define MD_MULH_FUN3   3'b001
`define MD_MULHSU_FUN3 3'b010
`define MD_MULHU_FUN3  3'b011
`endif

package sys_defs;

  // Global default depth of the multiplier pipeline (legal: 1, 2, 4, 8).
  localparam int MULT_STAGES = 4;

  typedef struct packed {
    logic                   valid;
    logic [2:0]             funct3;
    logic [`CDB_BITS-1:0]   dest_tag;
    logic [2*`XLEN-1:0]     a_ext;
    logic [2*`XLEN-1:0]     b_ext;
    logic [2*`XLEN-1:0]     acc;
  } MULT_STAGE_PACKET;

  // Pick the architectural result out of the full double-width product.
  // Unknown funct3 codes complete normally with a zero result.
  function automatic logic [`XLEN-1:0] mult_select(input logic [2:0]         funct3,
                                                    input logic [2*`XLEN-1:0] product);
    case (funct3)
      `MD_MUL_FUN3:    return product[`XLEN-1:0];
      `MD_MULH_FUN3,
      `MD_MULHSU_FUN3,
      `MD_MULHU_FUN3:  return product[2*`XLEN-1:`XLEN];
      default:         return '0;
    endcase
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One combinational partial-product step: multiplies the extended A operand
// by this stage's slice of extended B, shifts it into position and adds it
// to the running accumulator. All other packet fields pass straight through.
//
// Ports:
//   stage_in  - packet arriving at this stage
//   stage_out - same packet with acc updated
module mult_stage #(
  parameter int STAGE_IDX = 0,
  parameter int SLICE_W   = 16
) (
  input  sys_defs::MULT_STAGE_PACKET stage_in,
  output sys_defs::MULT_STAGE_PACKET stage_out
);
  localparam int PW = 2*`XLEN;

  logic [SLICE_W-1:0] slice;
  logic [PW-1:0]      partial;

  always_comb begin
    slice         = stage_in.b_ext[STAGE_IDX*SLICE_W +: SLICE_W];
    // Product and shift are truncated to PW bits: accumulation is mod 2^PW.
    partial       = (stage_in.a_ext * PW'(slice)) << (STAGE_IDX*SLICE_W);
    stage_out     = stage_in;
    stage_out.acc = stage_in.acc + partial;
  end

endmodule

// File: rtl/ex_mult_unit.sv
// Pipelined integer multiplier for one issue lane (MUL/MULH/MULHSU/MULHU).
// Each of MULT_STAGES register stages folds one slice of B into the
// accumulator; the last stage register is the output slot waiting for the
// CDB. The whole pipe freezes while that slot is valid and not granted.
//
// Ports:
//   clock, reset             - clock; async active-high reset
//   in_valid/in_ready        - issue handshake
//   in_rs1_value/in_rs2_value- operands
//   in_funct3, in_dest_tag   - op select and destination physical register
//   flush                    - squash everything in flight
//   cdb_grant                - CDB accepts the current output
//   out_valid/out_dest_tag/out_result - result waiting for the CDB
//   busy_count               - number of valid ops in the pipe
module ex_mult_unit #(
  parameter int MULT_STAGES = sys_defs::MULT_STAGES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [`XLEN-1:0]            in_rs1_value,
  input  logic [`XLEN-1:0]            in_rs2_value,
  input  logic [2:0]                  in_funct3,
  input  logic [`CDB_BITS-1:0]        in_dest_tag,
  input  logic                        flush,
  input  logic                        cdb_grant,
  output logic                        out_valid,
  output logic [`CDB_BITS-1:0]        out_dest_tag,
  output logic [`XLEN-1:0]            out_result,
  output logic [$clog2(MULT_STAGES):0] busy_count
);
  import sys_defs::*;

  localparam int PW      = 2*`XLEN;
  localparam int SLICE_W = PW / MULT_STAGES;
  localparam int CW      = $clog2(MULT_STAGES) + 1;

  MULT_STAGE_PACKET issue_pkt;
  MULT_STAGE_PACKET stage_in   [MULT_STAGES];
  MULT_STAGE_PACKET stage_comb [MULT_STAGES];
  MULT_STAGE_PACKET stage_q    [MULT_STAGES];

  logic stall;
  logic sgn_a, sgn_b;

  assign out_valid    = stage_q[MULT_STAGES-1].valid;
  assign out_dest_tag = stage_q[MULT_STAGES-1].dest_tag;
  assign out_result   = mult_select(stage_q[MULT_STAGES-1].funct3, stage_q[MULT_STAGES-1].acc);

  // A full pipe still accepts when the output slot drains this cycle.
  assign stall    = out_valid && !cdb_grant;
  assign in_ready = !stall;

  // Stage-0 operand extension.
  always_comb begin
    sgn_a              = (in_funct3 == `MD_MULH_FUN3) || (in_funct3 == `MD_MULHSU_FUN3);
    sgn_b              = (in_funct3 == `MD_MULH_FUN3);
    issue_pkt          = '0;
    issue_pkt.valid    = in_valid;
    issue_pkt.funct3   = in_funct3;
    issue_pkt.dest_tag = in_dest_tag;
    issue_pkt.a_ext    = {{`XLEN{sgn_a & in_rs1_value[`XLEN-1]}}, in_rs1_value};
    issue_pkt.b_ext    = {{`XLEN{sgn_b & in_rs2_value[`XLEN-1]}}, in_rs2_value};
  end

  for (genvar k = 0; k < MULT_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = issue_pkt;
    end else begin : g_body
      assign stage_in[k] = stage_q[k-1];
    end
    mult_stage #(.STAGE_IDX(k), .SLICE_W(SLICE_W)) u_stage (
      .stage_in  (stage_in[k]),
      .stage_out (stage_comb[k])
    );
  end

  // Flush beats stall and grant; data registers are don't-care once their
  // valid bit is cleared, so only the valid bits are touched.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MULT_STAGES; k++) stage_q[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < MULT_STAGES; k++) stage_q[k].valid <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < MULT_STAGES; k++) stage_q[k] <= stage_comb[k];
    end
  end

  always_comb begin
    busy_count = '0;
    for (int k = 0; k < MULT_STAGES; k++) busy_count = busy_count + CW'(stage_q[k].valid);
  end

endmodule

// File: tb/tb_ex_mult_unit.sv
`ifndef XLEN
`define XLEN 32
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif
`ifndef MD_MUL_FUN3
`define MD_MUL_FUN3    3'b000
`define MD_MULH_FUN3   3'b001
`define MD_MULHSU_FUN3 3'b010
`define MD_MULHU_FUN3  3'b011
`endif

module tb_ex_mult_unit;

  typedef struct {
    logic [`CDB_BITS-1:0] tag;
    logic [`XLEN-1:0]     res;
  } exp_t;

  logic                 clock, reset;
  logic                 in_valid, in_ready, flush, cdb_grant, out_valid;
  logic [`XLEN-1:0]     in_rs1_value, in_rs2_value, out_result;
  logic [2:0]           in_funct3;
  logic [`CDB_BITS-1:0] in_dest_tag, out_dest_tag;
  logic [2:0]           busy_count;

  logic                 c1_in_valid, c1_in_ready, c1_flush, c1_grant, c1_out_valid;
  logic [`XLEN-1:0]     c1_rs1, c1_rs2, c1_out_result;
  logic [2:0]           c1_funct3;
  logic [`CDB_BITS-1:0] c1_tag, c1_out_tag;
  logic [0:0]           c1_busy;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  bit   done;

  ex_mult_unit #(.MULT_STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value), .in_funct3(in_funct3),
    .in_dest_tag(in_dest_tag), .flush(flush), .cdb_grant(cdb_grant),
    .out_valid(out_valid), .out_dest_tag(out_dest_tag), .out_result(out_result),
    .busy_count(busy_count)
  );

  ex_mult_unit #(.MULT_STAGES(1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(c1_in_valid), .in_ready(c1_in_ready),
    .in_rs1_value(c1_rs1), .in_rs2_value(c1_rs2), .in_funct3(c1_funct3),
    .in_dest_tag(c1_tag), .flush(c1_flush), .cdb_grant(c1_grant),
    .out_valid(c1_out_valid), .out_dest_tag(c1_out_tag), .out_result(c1_out_result),
    .busy_count(c1_busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Reference multiply done with plain 64-bit arithmetic.
  function automatic logic [31:0] exp_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sp;
    longint unsigned up;
    case (f3)
      3'd0: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); return up[31:0]; end
      3'd1: begin sp = longint'(int'(a)) * longint'(int'(b)); return sp[63:32]; end
      3'd2: begin sp = longint'(int'(a)) * longint'({32'b0, b}); return sp[63:32]; end
      3'd3: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); return up[63:32]; end
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard monitor: pops on every granted output, and checks that a
  // stalled output stays put until granted.
  initial begin : monitor
    logic                 prev_hold;
    logic [`CDB_BITS-1:0] prev_tag;
    logic [`XLEN-1:0]     prev_res;
    exp_t                 e;
    prev_hold = 1'b0;
    prev_tag  = '0;
    prev_res  = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          checks++;
          if (out_valid !== 1'b1 || out_dest_tag !== prev_tag || out_result !== prev_res) begin
            failures++;
            $display("FAIL hold_stable: got valid=%0b tag=%0d result=%h, want valid=1 tag=%0d result=%h",
                     out_valid, out_dest_tag, out_result, prev_tag, prev_res);
          end
        end
        if (out_valid === 1'b1 && cdb_grant === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got tag=%0d result=%h, want no result", out_dest_tag, out_result);
          end else begin
            e = sb.pop_front();
            if (out_dest_tag !== e.tag || out_result !== e.res) begin
              failures++;
              $display("FAIL scoreboard: got tag=%0d result=%h, want tag=%0d result=%h",
                       out_dest_tag, out_result, e.tag, e.res);
            end
          end
        end
        prev_hold = (out_valid === 1'b1) && (cdb_grant !== 1'b1) && (flush !== 1'b1);
        prev_tag  = out_dest_tag;
        prev_res  = out_result;
      end
    end
  end

  // Call at a rising edge; returns at the edge that accepts the op, with
  // in_valid still high. Pushes the expected result on acceptance.
  task automatic send_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [`CDB_BITS-1:0] tag, input logic [31:0] res);
    bit   rdy;
    exp_t e;
    #1;
    in_valid = 1'b1; in_funct3 = f3; in_rs1_value = a; in_rs2_value = b; in_dest_tag = tag;
    rdy = 1'b0;
    for (int c = 0; c < 64 && !rdy; c++) begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL send_timeout: tag=%0d never accepted, want acceptance within 64 cycles", tag);
    end else begin
      e.tag = tag; e.res = res;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (sb.size() == 0 && out_valid === 1'b0 && busy_count === 3'd0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL drain: got pending=%0d busy=%0d, want pending=0 busy=0", sb.size(), busy_count);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || busy_count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ctrl: got valid=%0b busy=%0d ready=%0b, want 0 0 1", out_valid, busy_count, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_dest_tag !== '0) begin
      failures++;
      $display("FAIL reset_data: got result=%h tag=%0d, want 0 0", out_result, out_dest_tag);
    end
    checks++;
    if (c1_out_valid !== 1'b0 || c1_busy !== 1'b0 || c1_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_s1: got valid=%0b busy=%0d ready=%0b, want 0 0 1", c1_out_valid, c1_busy, c1_in_ready);
    end
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Accept edge was just passed; out_valid must appear after edge N+3.
  task automatic check_latency(input string name, input logic [`CDB_BITS-1:0] tag, input logic [31:0] res);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== (k == 3)) begin
        failures++;
        $display("FAIL %s_latency: cycle %0d got valid=%0b, want %0b", name, k, out_valid, (k == 3));
      end
      if (k == 0) begin
        checks++;
        if (busy_count !== 3'd1) begin
          failures++;
          $display("FAIL %s_busy: got %0d, want 1", name, busy_count);
        end
      end
      if (k == 3) begin
        checks++;
        if (out_result !== res || out_dest_tag !== tag) begin
          failures++;
          $display("FAIL %s_value: got result=%h tag=%0d, want result=%h tag=%0d", name, out_result, out_dest_tag, res, tag);
        end
      end
    end
  endtask

  task automatic test_mul_basic();
    cdb_grant = 1'b1;
    @(posedge clock);
    send_op(`MD_MUL_FUN3, 32'd7, 32'd6, 6'd32, 32'd42);
    #1 in_valid = 1'b0;
    check_latency("mul_7x6", 6'd32, 32'd42);
    drain();
  endtask

  task automatic test_funct3_corners();
    cdb_grant = 1'b1;
    @(posedge clock);
    send_op(`MD_MULH_FUN3,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd1, 32'h0000_0000);
    send_op(`MD_MULHU_FUN3,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd2, 32'hFFFF_FFFE);
    send_op(`MD_MULHSU_FUN3, 32'hFFFF_FFFF, 32'd2,         6'd3, 32'hFFFF_FFFF);
    send_op(3'b101,          32'd7,         32'd6,         6'd4, 32'h0000_0000);
    send_op(3'b111,          32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd5, 32'h0000_0000);
    send_op(`MD_MUL_FUN3,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 32'h0000_0001);
    send_op(`MD_MULH_FUN3,   32'h8000_0000, 32'h8000_0000, 6'd7, 32'h4000_0000);
    send_op(`MD_MULHSU_FUN3, 32'h8000_0000, 32'hFFFF_FFFF, 6'd8, 32'h8000_0000);
    #1 in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int   idx = 0;
    int   stalls = 0;
    bit   rdy;
    exp_t e;
    cdb_grant = 1'b0;
    @(posedge clock);
    for (int cyc = 0; cyc < 40 && idx < 6; cyc++) begin
      #1;
      in_valid = 1'b1;
      in_funct3 = 3'(idx % 4);
      in_rs1_value = 32'(idx * 3 + 1) | 32'hF000_0000;
      in_rs2_value = 32'(idx + 10);
      in_dest_tag = 6'(10 + idx);
      cdb_grant = (stalls >= 3);
      @(negedge clock);
      if (out_valid === 1'b1 && cdb_grant === 1'b0) begin
        stalls++;
        checks++;
        if (in_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready: got %0b, want 0", in_ready);
        end
        checks++;
        if (busy_count !== 3'd4) begin
          failures++;
          $display("FAIL b2b_busy: got %0d, want 4", busy_count);
        end
      end
      rdy = in_ready;
      @(posedge clock);
      if (rdy) begin
        e.tag = in_dest_tag;
        e.res = exp_result(in_funct3, in_rs1_value, in_rs2_value);
        sb.push_back(e);
        idx++;
      end
    end
    #1 in_valid = 1'b0; cdb_grant = 1'b1;
    checks++;
    if (idx != 6 || stalls != 3) begin
      failures++;
      $display("FAIL b2b_count: got issued=%0d stalls=%0d, want 6 3", idx, stalls);
    end
    drain();
  endtask

  task automatic test_random_stall();
    done = 1'b0;
    @(posedge clock);
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0]  f3;
          logic [31:0] a, b;
          f3 = 3'($urandom_range(0, 7));
          a  = rand_operand();
          b  = rand_operand();
          send_op(f3, a, b, 6'(i), exp_result(f3, a, b));
        end
        #1 in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clock);
          #1;
          if (!done) cdb_grant = ($urandom_range(0, 3) != 0);
        end
        cdb_grant = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_flush();
    cdb_grant = 1'b1;
    @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      #1;
      in_valid = 1'b1; in_funct3 = `MD_MUL_FUN3;
      in_rs1_value = 32'(i + 2); in_rs2_value = 32'd9; in_dest_tag = 6'(40 + i);
      @(negedge clock);
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_fill_ready: got %0b, want 1", in_ready);
      end
      @(posedge clock);
    end
    #1;
    in_rs1_value = 32'd11; in_dest_tag = 6'd50; flush = 1'b1;
    @(negedge clock);
    checks++;
    if (busy_count !== 3'd3) begin
      failures++;
      $display("FAIL flush_pre_busy: got %0d, want 3", busy_count);
    end
    @(posedge clock);
    #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (busy_count !== 3'd0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: got busy=%0d valid=%0b, want 0 0", busy_count, out_valid);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost: got valid=%0b tag=%0d, want no result", out_valid, out_dest_tag);
      end
    end
    // Flush must also win over a stalled, ungranted output.
    @(posedge clock);
    #1 cdb_grant = 1'b0; in_valid = 1'b1; in_funct3 = `MD_MUL_FUN3;
    in_rs1_value = 32'd5; in_rs2_value = 32'd5; in_dest_tag = 6'd51;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall_setup: got valid=%0b ready=%0b, want 1 0", out_valid, in_ready);
    end
    flush = 1'b1;
    @(posedge clock);
    #1 flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy_count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_over_stall: got valid=%0b busy=%0d ready=%0b, want 0 0 1", out_valid, busy_count, in_ready);
    end
    cdb_grant = 1'b1;
    drain();
  endtask

  task automatic test_reset_midflight();
    @(posedge clock);
    #1 cdb_grant = 1'b0; in_valid = 1'b1; in_funct3 = `MD_MUL_FUN3;
    in_rs1_value = 32'd4; in_rs2_value = 32'd4; in_dest_tag = 6'd20;
    @(posedge clock);
    #1 in_dest_tag = 6'd21; in_rs1_value = 32'd8;
    @(posedge clock);
    #1 in_valid = 1'b0;
    @(posedge clock); @(posedge clock);
    #2;
    checks++;
    if (busy_count !== 3'd2 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got busy=%0d valid=%0b, want 2 1", busy_count, out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy_count !== 3'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_async: got valid=%0b busy=%0d ready=%0b, want 0 0 1", out_valid, busy_count, in_ready);
    end
    checks++;
    if (out_result !== 32'h0 || out_dest_tag !== '0) begin
      failures++;
      $display("FAIL rst_async_data: got result=%h tag=%0d, want 0 0", out_result, out_dest_tag);
    end
    @(posedge clock); @(posedge clock);
    #1 reset = 1'b0; cdb_grant = 1'b1;
    @(posedge clock);
    send_op(`MD_MUL_FUN3, 32'd3, 32'd5, 6'd9, 32'd15);
    #1 in_valid = 1'b0;
    check_latency("post_reset", 6'd9, 32'd15);
    drain();
  endtask

  task automatic test_single_stage();
    c1_grant = 1'b1;
    @(posedge clock);
    #1 c1_in_valid = 1'b1; c1_funct3 = `MD_MUL_FUN3;
    c1_rs1 = 32'h8000_0000; c1_rs2 = 32'd2; c1_tag = 6'd5;
    @(negedge clock);
    checks++;
    if (c1_out_valid !== 1'b0 || c1_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL s1_pre: got valid=%0b ready=%0b, want 0 1", c1_out_valid, c1_in_ready);
    end
    @(posedge clock);
    #1 c1_funct3 = `MD_MULHU_FUN3; c1_rs1 = 32'hFFFF_FFFF; c1_rs2 = 32'hFFFF_FFFF; c1_tag = 6'd6;
    @(negedge clock);
    checks++;
    if (c1_out_valid !== 1'b1 || c1_out_result !== 32'h0 || c1_out_tag !== 6'd5 || c1_busy !== 1'b1) begin
      failures++;
      $display("FAIL s1_mul: got valid=%0b result=%h tag=%0d busy=%0d, want 1 00000000 5 1",
               c1_out_valid, c1_out_result, c1_out_tag, c1_busy);
    end
    @(posedge clock);
    #1 c1_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (c1_out_valid !== 1'b1 || c1_out_result !== 32'hFFFF_FFFE || c1_out_tag !== 6'd6) begin
      failures++;
      $display("FAIL s1_mulhu: got valid=%0b result=%h tag=%0d, want 1 fffffffe 6", c1_out_valid, c1_out_result, c1_out_tag);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (c1_out_valid !== 1'b0 || c1_busy !== 1'b0) begin
      failures++;
      $display("FAIL s1_drain: got valid=%0b busy=%0d, want 0 0", c1_out_valid, c1_busy);
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_rs1_value = '0; in_rs2_value = '0; in_funct3 = '0; in_dest_tag = '0;
    flush = 1'b0; cdb_grant = 1'b1;
    c1_in_valid = 1'b0; c1_rs1 = '0; c1_rs2 = '0; c1_funct3 = '0; c1_tag = '0;
    c1_flush = 1'b0; c1_grant = 1'b1;
    test_reset();
    test_mul_basic();
    test_funct3_corners();
    test_back_to_back();
    test_random_stall();
    test_flush();
    test_reset_midflight();
    test_single_stage();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mult_unit.md
EX_MULT_UNIT -- requirements
Module: ex_mult_unit

Interface
REQ-001 SHALL have parameter MULT_STAGES, default 4, number of pipeline stages; legal values 1, 2, 4, 8.
REQ-002 SHALL take widths from the shared macros: `XLEN for operands and results, `CDB_BITS for physical-register tags.
REQ-003 SHALL have port: clock  input  1  single clock for all state.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-high; acts on assertion, independent of clock.
REQ-005 SHALL have port: in_valid  input  1  issue lane presents a multiply op.
REQ-006 SHALL have port: in_ready  output  1  unit can accept an op this cycle.
REQ-007 SHALL have port: in_rs1_value  input  `XLEN  operand A, already read by the issue stage.
REQ-008 SHALL have port: in_rs2_value  input  `XLEN  operand B.
REQ-009 SHALL have port: in_funct3  input  3  one of `MD_MUL_FUN3, `MD_MULH_FUN3, `MD_MULHSU_FUN3, `MD_MULHU_FUN3.
REQ-010 SHALL have port: in_dest_tag  input  `CDB_BITS  destination physical register.
REQ-011 SHALL have port: flush  input  1  squash all in-flight ops (branch mispredict).
REQ-012 SHALL have port: cdb_grant  input  1  CDB arbiter accepts the current output this cycle.
REQ-013 SHALL have port: out_valid  output  1  a result is waiting for the CDB.
REQ-014 SHALL have port: out_dest_tag  output  `CDB_BITS  tag of the waiting result.
REQ-015 SHALL have port: out_result  output  `XLEN  the waiting result.
REQ-016 SHALL have port: busy_count  output  $clog2(MULT_STAGES)+1  number of valid ops in the pipeline.

Function
REQ-017 SHALL accept an op on a rising edge where in_valid && in_ready && !flush.
REQ-018 SHALL drive in_ready = !(out_valid && !cdb_grant), combinationally; a full pipeline still accepts when the last stage drains that cycle.
REQ-019 SHALL use a stall condition of out_valid && !cdb_grant; during a stall every stage register, including valid bits, holds its value.
REQ-020 SHALL present an op accepted at edge N with out_valid=1 after edge N+MULT_STAGES-1 when there are no stalls; each stall cycle adds exactly one cycle.
REQ-021 SHALL keep out_valid, out_dest_tag and out_result stable until the edge where cdb_grant=1.
REQ-022 SHALL extend operands to 2*`XLEN at stage 0: rs1 sign-extended for MULH and MULHSU, rs2 sign-extended for MULH only; otherwise zero-extend.
REQ-023 SHALL, in stage k, add (extended A × slice k of extended B, where a slice is 2*`XLEN/MULT_STAGES bits) shifted left by k*slice width into a 2*`XLEN accumulator; wrap is modulo 2^(2*`XLEN).
REQ-024 SHALL output product[`XLEN-1:0] for MUL and product[2*`XLEN-1:`XLEN] for MULH, MULHSU and MULHU.
REQ-025 SHALL accept any other funct3 value and produce out_result=0 with the normal latency and tag.
REQ-026 SHALL, when flush=1 at an edge, clear all stage valid bits and out_valid, and ignore in_valid that cycle; flush has priority over stall and over cdb_grant.
REQ-027 SHALL keep busy_count equal to the population count of the stage valid bits, registered-state based and never exceeding MULT_STAGES.
REQ-028 SHALL ignore cdb_grant while out_valid=0.

Reset
REQ-029 SHALL, on reset assertion, clear immediately: all stage valid bits, out_valid=0, busy_count=0, in_ready=1.
REQ-030 SHALL reset data and tag registers to 0; ops in flight are discarded, and the first op accepted after reset deasserts behaves per REQ-020.

Structure
REQ-031 SHALL take the MD_*_FUN3 codes, `XLEN and `CDB_BITS from the shared sys_defs package, and add MULT_STAGES there as a global default.
REQ-032 SHALL declare a MULT_STAGE_PACKET struct {valid, funct3, dest_tag, a_ext, b_ext, acc} in the shared package.
REQ-033 SHALL use one sub-module, mult_stage, for one combinational partial-product/accumulate step, instantiated MULT_STAGES times.
REQ-034 SHALL be instantiated once per issue lane, with N_WAY copies in the execute stage.

Verification
REQ-035 SHALL cover: MUL 7×6, tag 32, grant held 1 -> out_valid 4 cycles after accept, out_result=42, out_dest_tag=32.
REQ-036 SHALL cover: MULH 0xFFFFFFFF×0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×2 -> 0xFFFFFFFF.
REQ-037 SHALL cover: back-to-back 6 ops, cdb_grant=0 for 3 cycles once output valid -> in_ready=0 for those cycles, busy_count=4, no op lost or reordered, results in issue order.
REQ-038 SHALL cover: flush with 3 ops in flight plus in_valid=1 -> next cycle busy_count=0, out_valid=0, and no result ever appears for the 4 squashed ops.
REQ-039 SHALL cover: reset asserted mid-cycle with 2 ops in flight -> out_valid and busy_count drop before the next edge; a new MUL 3×5 after reset -> 15 with nominal latency.
REQ-040 SHALL cover: MULT_STAGES=1 build, MUL 0x80000000×2 -> out_valid the edge after accept, out_result=0x00000000.
